// File: rtl/arbitro_rr_4a1_32bits_if.sv
// Handshake bundle between four requesters and the round-robin arbiter of a 4:1 32-bit mux path.
// Signals: Solicitud (per-requester level request), Concesion (one-hot grant), Control (mux select),
//          Valido (grant active), Contador (cycles held by the current owner, minus one).
interface arbitro_rr_4a1_32bits_if #(
  parameter int MAX_RAFAGA = 8
);
  localparam int CW = $clog2(MAX_RAFAGA);

  logic [3:0]    Solicitud;
  logic [3:0]    Concesion;
  logic [1:0]    Control;
  logic          Valido;
  logic [CW-1:0] Contador;

  // Requester side drives requests and observes the grant.
  modport master (
    output Solicitud,
    input  Concesion, Control, Valido, Contador
  );

  // Arbiter side observes requests and drives the grant.
  modport slave (
    input  Solicitud,
    output Concesion, Control, Valido, Contador
  );
endinterface

// File: rtl/arbitro_rr_4a1_32bits.sv
// Round-robin arbiter granting one of four requesters the 32-bit 4:1 mux path, with a bounded burst.
// Latency: grant appears one edge after a request is sampled; handover between owners has no idle cycle.
// Ports: clk, rst_n (async active-low), bus (slave modport: Solicitud in; Concesion/Control/Valido/Contador out).
module arbitro_rr_4a1_32bits #(
  parameter int MAX_RAFAGA = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  arbitro_rr_4a1_32bits_if.slave   bus
);

  localparam int            CW      = $clog2(MAX_RAFAGA);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_RAFAGA - 1);

  typedef enum logic {
    LIBRE   = 1'b0,
    OCUPADO = 1'b1
  } estado_t;

  estado_t       estado;
  estado_t       estado_nxt;
  logic [1:0]    puntero;
  logic [1:0]    puntero_nxt;
  logic [1:0]    control_nxt;
  logic [CW-1:0] contador_nxt;
  logic [3:0]    concesion_nxt;
  logic          valido_nxt;

  // First asserted request walking start, start+1, ... modulo 4.
  function automatic logic [1:0] primero(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    logic       hallado;
    res     = start;
    hallado = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!hallado && req[idx]) begin
        res     = idx;
        hallado = 1'b1;
      end
    end
    return res;
  endfunction

  // State and all outputs are registered, so nothing reaches an output from Solicitud combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado        <= LIBRE;
      puntero       <= 2'd0;
      bus.Control   <= 2'd0;
      bus.Contador  <= '0;
      bus.Concesion <= 4'b0000;
      bus.Valido    <= 1'b0;
    end else begin
      estado        <= estado_nxt;
      puntero       <= puntero_nxt;
      bus.Control   <= control_nxt;
      bus.Contador  <= contador_nxt;
      bus.Concesion <= concesion_nxt;
      bus.Valido    <= valido_nxt;
    end
  end

  // Next state; Control doubles as the owner index while OCUPADO.
  always_comb begin
    estado_nxt   = estado;
    puntero_nxt  = puntero;
    control_nxt  = bus.Control;
    contador_nxt = bus.Contador;
    case (estado)
      LIBRE: begin
        if (|bus.Solicitud) begin
          estado_nxt   = OCUPADO;
          control_nxt  = primero(bus.Solicitud, puntero);
          contador_nxt = '0;
        end
      end
      OCUPADO: begin
        if (bus.Solicitud[bus.Control] && (bus.Contador != CNT_MAX)) begin
          contador_nxt = bus.Contador + CW'(1);
        end else begin
          // Release. Searching from owner+1 reaches the owner last, so it is
          // re-granted only when it is the sole requester (burst timeout).
          puntero_nxt  = bus.Control + 2'd1;
          contador_nxt = '0;
          if (|bus.Solicitud) begin
            control_nxt = primero(bus.Solicitud, bus.Control + 2'd1);
          end else begin
            estado_nxt  = LIBRE;
          end
        end
      end
      default: estado_nxt = LIBRE;
    endcase
  end

  // Grant outputs follow the next state; Control keeps its last value when idle.
  always_comb begin
    valido_nxt    = (estado_nxt == OCUPADO);
    concesion_nxt = 4'b0000;
    if (valido_nxt) begin
      concesion_nxt = 4'b0001 << control_nxt;
    end
  end

endmodule

// File: tb/tb_arbitro_rr_4a1_32bits.sv
// Self-checking bench for the round-robin arbiter: directed scenarios plus randomized traffic
// against a request-rule reference model; also drives a 4:1 32-bit mux from Control.
module tb_arbitro_rr_4a1_32bits;

  localparam int MR = 8;
  localparam int CW = $clog2(MR);
  localparam logic [31:0] ENTRADAS [4] = '{32'hAAAAAAAA, 32'hAAAABBBB, 32'hBBBBCCCC, 32'hCCCCDDDD};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arbitro_rr_4a1_32bits_if #(.MAX_RAFAGA(MR)) bus ();

  arbitro_rr_4a1_32bits #(.MAX_RAFAGA(MR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mux_out;
  always_comb begin
    case (bus.Control)
      2'd0:    mux_out = ENTRADAS[0];
      2'd1:    mux_out = ENTRADAS[1];
      2'd2:    mux_out = ENTRADAS[2];
      default: mux_out = ENTRADAS[3];
    endcase
  end

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 = nobody), cycles held so far, priority pointer, last select.
  int m_owner, m_cnt, m_ptr, m_ctl;

  function automatic int buscar(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_ctl = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    if (m_owner < 0) begin
      if (r != 4'b0) begin
        m_owner = buscar(r, m_ptr); m_cnt = 0; m_ctl = m_owner;
      end
    end else if (r[m_owner] && m_cnt < MR - 1) begin
      m_cnt = m_cnt + 1;
    end else begin
      m_ptr = (m_owner + 1) % 4;
      if (r != 4'b0) begin
        m_owner = buscar(r, m_ptr); m_cnt = 0; m_ctl = m_owner;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  function automatic logic [6:0] exp_vec();
    logic [3:0] c;
    c = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    return {(m_owner >= 0), c, 2'(m_ctl)};
  endfunction

  // Drive a request vector after the falling edge, optionally with an unsampled glitch first.
  task automatic tick(input logic [3:0] r, input logic glitch);
    @(negedge clk);
    if (glitch) begin
      bus.Solicitud = ~r;
      #2;
    end
    bus.Solicitud = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.Solicitud = 4'b0000;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Solicitud = 4'b1111;
    model_reset();
    #2;
    checks++;
    if ({bus.Valido, bus.Concesion, bus.Control, bus.Contador} !== {1'b0, 4'b0000, 2'b00, CW'(0)}) begin
      errors++;
      $display("FAIL reset_async: got vld/conc/ctl/cnt %b want all zero",
               {bus.Valido, bus.Concesion, bus.Control, bus.Contador});
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.Valido, bus.Concesion} !== 5'b0) begin
      errors++;
      $display("FAIL reset_held_edge: got vld/conc %b want 00000", {bus.Valido, bus.Concesion});
    end
    bus.Solicitud = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_two_requesters();
    do_reset();
    tick(4'b0101, 1'b0);
    checks++;
    if ({bus.Valido, bus.Concesion, bus.Control} !== 7'b1_0001_00) begin
      errors++;
      $display("FAIL two_req_first: got %b want 1000100", {bus.Valido, bus.Concesion, bus.Control});
    end
    tick(4'b0100, 1'b0);
    checks++;
    if ({bus.Valido, bus.Concesion, bus.Control} !== 7'b1_0100_10) begin
      errors++;
      $display("FAIL two_req_handover: got %b want 1010010", {bus.Valido, bus.Concesion, bus.Control});
    end
    checks++;
    if (mux_out !== ENTRADAS[2]) begin
      errors++;
      $display("FAIL two_req_mux: got %h want %h", mux_out, ENTRADAS[2]);
    end
  endtask

  task automatic test_full_rotation();
    do_reset();
    for (int i = 0; i < 4 * MR + 3; i++) begin
      tick(4'b1111, 1'b0);
      checks++;
      if ({bus.Valido, bus.Concesion, bus.Control} !== exp_vec()) begin
        errors++;
        $display("FAIL rotation_grant cyc %0d: got %b want %b", i,
                 {bus.Valido, bus.Concesion, bus.Control}, exp_vec());
      end
      // Owner sequence 0,1,2,3,0 with MR cycles each and the counter running 0..MR-1.
      checks++;
      if (bus.Control !== 2'((i / MR) % 4) || bus.Contador !== CW'(i % MR)) begin
        errors++;
        $display("FAIL rotation_order cyc %0d: got ctl %0d cnt %0d want ctl %0d cnt %0d", i,
                 bus.Control, bus.Contador, (i / MR) % 4, i % MR);
      end
    end
  endtask

  task automatic test_timeout_single();
    do_reset();
    for (int i = 0; i < 3 * MR; i++) begin
      tick(4'b1000, 1'b0);
      checks++;
      if ({bus.Valido, bus.Concesion, bus.Control} !== 7'b1_1000_11 || bus.Contador !== CW'(i % MR)) begin
        errors++;
        $display("FAIL timeout_regrant cyc %0d: got %b cnt %0d want 1100011 cnt %0d", i,
                 {bus.Valido, bus.Concesion, bus.Control}, bus.Contador, i % MR);
      end
      checks++;
      if (mux_out !== ENTRADAS[3]) begin
        errors++;
        $display("FAIL timeout_mux cyc %0d: got %h want %h", i, mux_out, ENTRADAS[3]);
      end
    end
  endtask

  task automatic test_idle_wrap();
    do_reset();
    tick(4'b0010, 1'b0);
    tick(4'b0000, 1'b0);
    checks++;
    if ({bus.Valido, bus.Concesion, bus.Control} !== 7'b0_0000_01) begin
      errors++;
      $display("FAIL idle_hold_ctl: got %b want 0000001", {bus.Valido, bus.Concesion, bus.Control});
    end
    tick(4'b0000, 1'b0);
    // Pointer is now 2; the search 2,3,0,1 reaches requester 0 before 1.
    tick(4'b0011, 1'b0);
    checks++;
    if ({bus.Valido, bus.Concesion, bus.Control} !== exp_vec()) begin
      errors++;
      $display("FAIL idle_wrap_grant: got %b want %b", {bus.Valido, bus.Concesion, bus.Control}, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) tick(4'b0010, 1'b0);
    checks++;
    if (bus.Concesion !== 4'b0010 || bus.Contador !== CW'(3)) begin
      errors++;
      $display("FAIL async_pre: got conc %b cnt %0d want 0010 cnt 3", bus.Concesion, bus.Contador);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.Valido, bus.Concesion, bus.Control, bus.Contador} !== {1'b0, 4'b0000, 2'b00, CW'(0)}) begin
      errors++;
      $display("FAIL async_drop: got %b want all zero",
               {bus.Valido, bus.Concesion, bus.Control, bus.Contador});
    end
    model_reset();
    bus.Solicitud = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick(4'b0110, 1'b0);
    checks++;
    if ({bus.Valido, bus.Concesion, bus.Control} !== 7'b1_0010_01) begin
      errors++;
      $display("FAIL async_first_grant: got %b want 1001001", {bus.Valido, bus.Concesion, bus.Control});
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 25) r = 4'($urandom_range(0, 15));
      tick(r, ($urandom_range(0, 9) == 0));
      checks++;
      if ({bus.Valido, bus.Concesion, bus.Control} !== exp_vec()) begin
        errors++;
        $display("FAIL random_grant cyc %0d req %b: got %b want %b", i, r,
                 {bus.Valido, bus.Concesion, bus.Control}, exp_vec());
      end
      if (m_owner >= 0) begin
        checks++;
        if (bus.Contador !== CW'(m_cnt)) begin
          errors++;
          $display("FAIL random_cnt cyc %0d: got %0d want %0d", i, bus.Contador, m_cnt);
        end
        checks++;
        if (mux_out !== ENTRADAS[m_owner]) begin
          errors++;
          $display("FAIL random_mux cyc %0d: got %h want %h", i, mux_out, ENTRADAS[m_owner]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_requesters();
    test_full_rotation();
    test_timeout_single();
    test_idle_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
